// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writebacks vs. a 2-entry FIFO of
// long-latency (mul/div) results, with WAW stall and anti-starvation forcing.
module rf_wport_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        p_valid_i,
    input  logic [4:0]  p_rd_i,
    input  logic [31:0] p_data_i,
    output logic        p_ready_o,
    input  logic        m_valid_i,
    input  logic [4:0]  m_rd_i,
    input  logic [31:0] m_data_i,
    output logic        m_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] pend_mask_o,
    output logic [1:0]  fifo_cnt_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]    cnt_q, cnt_d;
    logic [4:0]    ent_rd_q [2];
    logic [4:0]    ent_rd_d [2];
    logic [31:0]   ent_data_q [2];
    logic [31:0]   ent_data_d [2];
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;

    logic          non_empty, hit0, hit1, hz, force_fwd;
    logic          grant_p, pop, push;
    logic [1:0]    wr_idx;

    assign non_empty = (cnt_q != 2'd0);
    assign hit0      = non_empty && (ent_rd_q[0] == p_rd_i);
    assign hit1      = (cnt_q == 2'd2) && (ent_rd_q[1] == p_rd_i);
    assign hz        = p_valid_i && (p_rd_i != 5'd0) && (hit0 || hit1);
    assign force_fwd = (starve_q == SW'(STARVE_MAX)) && non_empty;

    assign p_ready_o = !(hz || force_fwd);
    assign m_ready_o = (cnt_q != 2'd2);
    assign grant_p   = p_valid_i && p_ready_o;
    assign pop       = !grant_p && non_empty;
    assign push      = m_valid_i && m_ready_o;

    // FIFO is a shift structure: entry 0 is always the head.
    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        cnt_d      = cnt_q;
        wr_idx     = pop ? (cnt_q - 2'd1) : cnt_q;
        if (pop) begin
            ent_rd_d[0]   = ent_rd_q[1];
            ent_data_d[0] = ent_data_q[1];
        end
        if (push) begin
            ent_rd_d[wr_idx[0]]   = m_rd_i;
            ent_data_d[wr_idx[0]] = m_data_i;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || !non_empty)
            starve_d = '0;
        else if (grant_p && (starve_q != SW'(STARVE_MAX)))
            starve_d = starve_q + SW'(1);
    end

    // A winner targeting x0 is consumed but never raises the write enable.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_p) begin
            rf_we_d    = (p_rd_i != 5'd0);
            rf_waddr_d = p_rd_i;
            rf_wdata_d = p_data_i;
        end else if (pop) begin
            rf_we_d    = (ent_rd_q[0] != 5'd0);
            rf_waddr_d = ent_rd_q[0];
            rf_wdata_d = ent_data_q[0];
        end
    end

    always_comb begin
        pend_mask_o = '0;
        if (non_empty && (ent_rd_q[0] != 5'd0))
            pend_mask_o[ent_rd_q[0]] = 1'b1;
        if ((cnt_q == 2'd2) && (ent_rd_q[1] != 5'd0))
            pend_mask_o[ent_rd_q[1]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= 2'd0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Entry payloads are qualified by cnt_q, so they need no reset.
    always_ff @(posedge clk) begin
        ent_rd_q   <= ent_rd_d;
        ent_data_q <= ent_data_d;
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign fifo_cnt_o = cnt_q;
endmodule

// File: tb/tb_rf_wport_arb.sv
// Randomized + directed bench for rf_wport_arb against a queue-based reference model.
module tb_rf_wport_arb;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        p_valid_i = 1'b0;
    logic [4:0]  p_rd_i = '0;
    logic [31:0] p_data_i = '0;
    logic        p_ready_o;
    logic        m_valid_i = 1'b0;
    logic [4:0]  m_rd_i = '0;
    logic [31:0] m_data_i = '0;
    logic        m_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] pend_mask_o;
    logic [1:0]  fifo_cnt_o;

    rf_wport_arb #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rstn(rstn),
        .p_valid_i(p_valid_i), .p_rd_i(p_rd_i), .p_data_i(p_data_i), .p_ready_o(p_ready_o),
        .m_valid_i(m_valid_i), .m_rd_i(m_rd_i), .m_data_i(m_data_i), .m_ready_o(m_ready_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .pend_mask_o(pend_mask_o), .fifo_cnt_o(fifo_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    int          starve = 0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    int          n_checks = 0;
    int          n_errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        starve   = 0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    // One clock: drive at negedge, check registered + combinational outputs, advance the model.
    task automatic cyc(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        logic        hz, frc, prdy, mrdy, gp, popm;
        logic [31:0] pend;
        ent_t        e;
        @(negedge clk);
        p_valid_i = pv; p_rd_i = prd; p_data_i = pd;
        m_valid_i = mv; m_rd_i = mrd; m_data_i = md;
        #1;
        chk("rf_we", 32'(rf_we_o), 32'(exp_we));
        chk("rf_waddr", 32'(rf_waddr_o), 32'(exp_addr));
        chk("rf_wdata", rf_wdata_o, exp_data);

        hz = 1'b0;
        pend = '0;
        foreach (mq[i]) begin
            if (pv && prd != 0 && mq[i].rd == prd) hz = 1'b1;
            if (mq[i].rd != 0) pend[mq[i].rd] = 1'b1;
        end
        frc  = (starve == SMAX) && (mq.size() > 0);
        prdy = !(hz || frc);
        mrdy = (mq.size() < 2);
        chk("p_ready", 32'(p_ready_o), 32'(prdy));
        chk("m_ready", 32'(m_ready_o), 32'(mrdy));
        chk("pend_mask", pend_mask_o, pend);
        chk("fifo_cnt", 32'(fifo_cnt_o), 32'(mq.size()));

        gp   = pv && prdy;
        popm = !gp && (mq.size() > 0);
        if (gp) begin
            exp_we = (prd != 0); exp_addr = prd; exp_data = pd;
        end else if (popm) begin
            exp_we = (mq[0].rd != 0); exp_addr = mq[0].rd; exp_data = mq[0].data;
        end else begin
            exp_we = 1'b0;
        end
        if (popm || mq.size() == 0) starve = 0;
        else if (gp && starve < SMAX) starve++;
        if (popm) void'(mq.pop_front());
        if (mv && mrdy) begin
            e.rd = mrd; e.data = md;
            mq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        p_valid_i = 1'b0; m_valid_i = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_we", 32'(rf_we_o), 32'd0);
        chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_pend", pend_mask_o, 32'd0);
        chk("rst_cnt", 32'(fifo_cnt_o), 32'd0);
        chk("rst_m_ready", 32'(m_ready_o), 32'd1);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();

        // P only
        cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        idle(2);
        // M only
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
        idle(4);
        // FIFO fills while P streams, then starvation forces the head through
        cyc(1'b1, 5'd10, 32'h100, 1'b1, 5'd1, 32'hB1);
        cyc(1'b1, 5'd11, 32'h101, 1'b1, 5'd2, 32'hB2);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 5'(12 + i), 32'(32'h200 + i), 1'b1, 5'd4, 32'hC0);
        idle(4);
        // WAW on x3
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 32'd0);
        idle(2);
        // x0 from both sources
        cyc(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
        idle(3);
        // Reset with a full FIFO
        cyc(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
        cyc(1'b1, 5'd22, 32'h3, 1'b1, 5'd23, 32'h4);
        do_reset();
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom);
            if (i % 700 == 350) do_reset();
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
